// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: width codes, busy codes,
// controller states and byte-lane helpers.
package mem_ctrl_pkg;

    // Access width codes as driven on mem_width_in (2'b11 is treated as word).
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Busy codes reported on memctrl_busy_out.
    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_IF   = 2'b01;
    localparam logic [1:0] CTRL_MEM  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_MEM_RD,
        ST_MEM_WR
    } state_e;

    // Number of bytes moved for a given width code.
    function automatic logic [2:0] access_bytes(input logic [1:0] width);
        case (width)
            MEM_BYTE: access_bytes = 3'd1;
            MEM_HALF: access_bytes = 3'd2;
            default:  access_bytes = 3'd4;
        endcase
    endfunction

    // Replace byte lane 'lane' of 'word' with 'b'.
    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[8*lane +: 8] = b;
        return r;
    endfunction

    // Pick byte lane 'lane' out of 'word'.
    function automatic logic [7:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serves IF-stage fetches and MEM-stage loads/stores over a
// byte-serial external RAM port. MEM requests take priority and preempt an
// in-flight fetch, which restarts from byte 0 once the MEM access is done.
//
// Ports:
//   clk_in, rst_in (async, active-low)
//   if_req_in / if_addr_in          -> if_done_out / inst_out
//   read_req_in / write_req_in / mem_addr_in / mem_val_in / mem_width_in
//                                   -> mem_done_out / mem_val_read_out
//   memctrl_busy_out                 00 idle, 01 fetch, 10 MEM
//   mem_din / mem_dout / mem_a / mem_wr   external RAM (1-cycle read latency)
//   io_buffer_full_in               stalls writes into the I/O region
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [1:0]  IO_SEL     = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,

    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           inst_out,

    input  logic                  read_req_in,
    input  logic                  write_req_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [31:0]           mem_val_in,
    input  logic [1:0]            mem_width_in,
    output logic                  mem_done_out,
    output logic [31:0]           mem_val_read_out,

    output logic [1:0]            memctrl_busy_out,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,

    input  logic                  io_buffer_full_in
);

    state_e                state;
    logic [2:0]            stage;
    logic [2:0]            nbytes_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rbuf_q;

    logic                  mem_req;
    logic                  fetch_req;
    logic                  mem_accept;
    logic                  accept_blocked;
    logic                  wr_blocked;
    logic [31:0]           captured;

    // A requester drops its request during its own done cycle, so a request
    // still visible then is stale and must not be accepted again.
    assign mem_req   = (read_req_in | write_req_in) & ~mem_done_out;
    assign fetch_req = if_req_in & ~if_done_out;

    // MEM is taken from IDLE, or by aborting a fetch that is not on its
    // completing edge (stage == nbytes means the last byte lands now).
    assign mem_accept = mem_req &&
                        ((state == ST_IDLE) ||
                         (state == ST_IF_RD && stage != nbytes_q));

    assign accept_blocked = (mem_addr_in[17:16] == IO_SEL) & io_buffer_full_in;
    assign wr_blocked     = (addr_q[17:16] == IO_SEL) & io_buffer_full_in;

    // Byte on mem_din belongs to the address issued two edges ago, i.e. lane stage-1.
    assign captured = lane_insert(rbuf_q, stage[1:0] - 2'd1, mem_din);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= ST_IDLE;
            stage            <= '0;
            nbytes_q         <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            rbuf_q           <= '0;
            if_done_out      <= 1'b0;
            inst_out         <= '0;
            mem_done_out     <= 1'b0;
            mem_val_read_out <= '0;
            memctrl_busy_out <= CTRL_IDLE;
            mem_dout         <= '0;
            mem_a            <= '0;
            mem_wr           <= 1'b0;
        end else begin
            if_done_out  <= 1'b0;
            mem_done_out <= 1'b0;
            mem_wr       <= 1'b0;

            if (mem_accept) begin
                addr_q           <= mem_addr_in;
                nbytes_q         <= access_bytes(mem_width_in);
                wdata_q          <= mem_val_in;
                rbuf_q           <= '0;
                memctrl_busy_out <= CTRL_MEM;
                mem_a            <= mem_addr_in;
                if (write_req_in) begin
                    state <= ST_MEM_WR;
                    // For writes, stage counts bytes already issued.
                    if (accept_blocked) begin
                        stage <= 3'd0;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_dout <= mem_val_in[7:0];
                        stage    <= 3'd1;
                    end
                end else begin
                    state <= ST_MEM_RD;
                    stage <= 3'd0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fetch_req) begin
                            state            <= ST_IF_RD;
                            addr_q           <= if_addr_in;
                            nbytes_q         <= 3'd4;
                            rbuf_q           <= '0;
                            stage            <= 3'd0;
                            memctrl_busy_out <= CTRL_IF;
                            mem_a            <= if_addr_in;
                        end else begin
                            mem_a <= '0;
                        end
                    end

                    ST_IF_RD, ST_MEM_RD: begin
                        if (stage != 3'd0) begin
                            rbuf_q <= captured;
                        end
                        if (stage == nbytes_q) begin
                            state            <= ST_IDLE;
                            stage            <= 3'd0;
                            memctrl_busy_out <= CTRL_IDLE;
                            mem_a            <= '0;
                            if (state == ST_IF_RD) begin
                                inst_out    <= captured;
                                if_done_out <= 1'b1;
                            end else begin
                                mem_val_read_out <= captured;
                                mem_done_out     <= 1'b1;
                            end
                        end else begin
                            stage <= stage + 3'd1;
                            if (stage + 3'd1 < nbytes_q) begin
                                mem_a <= addr_q + ADDR_WIDTH'(stage + 3'd1);
                            end else begin
                                mem_a <= '0;
                            end
                        end
                    end

                    ST_MEM_WR: begin
                        if (stage == nbytes_q) begin
                            state            <= ST_IDLE;
                            stage            <= 3'd0;
                            memctrl_busy_out <= CTRL_IDLE;
                            mem_a            <= '0;
                            mem_done_out     <= 1'b1;
                        end else begin
                            mem_a <= addr_q + ADDR_WIDTH'(stage);
                            if (!wr_blocked) begin
                                mem_wr   <= 1'b1;
                                mem_dout <= lane_extract(wdata_q, stage[1:0]);
                                stage    <= stage + 3'd1;
                            end
                        end
                    end

                    default: begin
                        state            <= ST_IDLE;
                        stage            <= 3'd0;
                        memctrl_busy_out <= CTRL_IDLE;
                        mem_a            <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide RAM model
// (one-cycle read latency, writes on mem_wr at the clock edge).
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int ADDR_WIDTH = 32;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = '0;
    logic        if_done_out;
    logic [31:0] inst_out;
    logic        read_req_in = 1'b0;
    logic        write_req_in = 1'b0;
    logic [31:0] mem_addr_in = '0;
    logic [31:0] mem_val_in = '0;
    logic [1:0]  mem_width_in = '0;
    logic        mem_done_out;
    logic [31:0] mem_val_read_out;
    logic [1:0]  memctrl_busy_out;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full_in = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int if_done_cnt = 0;
    int mem_done_cnt = 0;

    logic [7:0] ram [0:262143];

    mem_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .IO_SEL(2'b11)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .if_req_in        (if_req_in),
        .if_addr_in       (if_addr_in),
        .if_done_out      (if_done_out),
        .inst_out         (inst_out),
        .read_req_in      (read_req_in),
        .write_req_in     (write_req_in),
        .mem_addr_in      (mem_addr_in),
        .mem_val_in       (mem_val_in),
        .mem_width_in     (mem_width_in),
        .mem_done_out     (mem_done_out),
        .mem_val_read_out (mem_val_read_out),
        .memctrl_busy_out (memctrl_busy_out),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .io_buffer_full_in(io_buffer_full_in)
    );

    always #5 clk_in = ~clk_in;

    // RAM: address sampled at the edge, read data visible the next cycle.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) ram[mem_a[17:0]] = mem_dout;
    end

    always @(negedge clk_in) begin
        if (if_done_out)  if_done_cnt  <= if_done_cnt + 1;
        if (mem_done_out) mem_done_cnt <= mem_done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_a"},  mem_a, 32'h0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
        check({tag, "_dout"},   32'(mem_dout), 32'h0);
        check({tag, "_busy"},   32'(memctrl_busy_out), 32'h0);
        check({tag, "_dones"},  32'({if_done_out, mem_done_out}), 32'h0);
        check({tag, "_inst"},   inst_out, 32'h0);
        check({tag, "_rdval"},  mem_val_read_out, 32'h0);
    endtask

    // kind: 0 fetch, 1 load, 2 store. io_cycles: edges held off by a full I/O buffer.
    task automatic run_txn(input string tag, input int kind, input logic [31:0] addr,
                           input logic [1:0] width, input logic [31:0] val,
                           input int exp_lat, input logic [31:0] exp_data,
                           input int io_cycles);
        int lat;
        int wr_cycles;
        int first_wr;
        int nb;
        nb = (width == MEM_BYTE) ? 1 : (width == MEM_HALF) ? 2 : 4;
        lat = 0;
        wr_cycles = 0;
        first_wr = 0;
        @(negedge clk_in);
        if (kind == 0) begin
            if_req_in = 1'b1; if_addr_in = addr;
        end else begin
            read_req_in  = (kind == 1);
            write_req_in = (kind == 2);
            mem_addr_in  = addr; mem_width_in = width; mem_val_in = val;
        end
        io_buffer_full_in = (io_cycles > 0);
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clk_in);
            if (i == io_cycles) io_buffer_full_in = 1'b0;
            if (i == 1)
                check({tag, "_busy"}, 32'(memctrl_busy_out), (kind == 0) ? 32'h1 : 32'h2);
            if (mem_wr) begin
                check({tag, "_wr_addr"}, mem_a, addr + 32'(wr_cycles));
                check({tag, "_wr_byte"}, 32'(mem_dout), 32'(val[8*wr_cycles +: 8]));
                if (wr_cycles == 0) first_wr = i;
                wr_cycles++;
            end
            if ((kind == 0) ? if_done_out : mem_done_out) lat = i;
        end
        if_req_in = 1'b0; read_req_in = 1'b0; write_req_in = 1'b0;
        io_buffer_full_in = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (kind == 0) check({tag, "_data"}, inst_out, exp_data);
        if (kind == 1) check({tag, "_data"}, mem_val_read_out, exp_data);
        if (kind == 2) begin
            check({tag, "_wr_cycles"}, 32'(wr_cycles), 32'(nb));
            check({tag, "_first_wr"}, 32'(first_wr), 32'(io_cycles + 1));
        end
        @(negedge clk_in);
        check({tag, "_pulse"}, 32'({if_done_out, mem_done_out}), 32'h0);
    endtask

    initial begin
        int lat;
        int stray;
        int done_snap;

        for (int a = 'h100; a < 'h400; a++) ram[a] = 8'h00;
        for (int a = 'h30000; a < 'h30004; a++) ram[a] = 8'h00;
        ram['h100] = 8'h13; ram['h101] = 8'h05; ram['h102] = 8'h00; ram['h103] = 8'h00;
        ram['h200] = 8'hEF; ram['h201] = 8'hBE; ram['h202] = 8'hAD; ram['h203] = 8'hDE;

        #2;
        check_reset_outputs("por");
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;

        run_txn("fetch",     0, 32'h100, MEM_WORD, 32'h0, 6, 32'h0000_0513, 0);
        run_txn("ld_word",   1, 32'h200, MEM_WORD, 32'h0, 6, 32'hDEAD_BEEF, 0);
        run_txn("ld_byte",   1, 32'h203, MEM_BYTE, 32'h0, 3, 32'h0000_00DE, 0);
        run_txn("ld_half",   1, 32'h200, MEM_HALF, 32'h0, 4, 32'h0000_BEEF, 0);
        run_txn("st_word",   2, 32'h300, MEM_WORD, 32'h1122_3344, 5, 32'h0, 0);
        check("st_ram", {ram['h303], ram['h302], ram['h301], ram['h300]}, 32'h1122_3344);
        run_txn("ld_back",   1, 32'h301, MEM_HALF, 32'h0, 4, 32'h0000_2233, 0);
        run_txn("io_store",  2, 32'h30000, MEM_BYTE, 32'h0000_005A, 5, 32'h0, 3);
        check("io_ram", 32'(ram['h30000]), 32'h5A);

        // Preemption: load raised while the fetch is two bytes in.
        @(negedge clk_in);
        if_req_in = 1'b1; if_addr_in = 32'h100;
        repeat (2) @(negedge clk_in);
        read_req_in = 1'b1; mem_addr_in = 32'h200; mem_width_in = MEM_WORD;
        lat = 0; stray = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clk_in);
            if (if_done_out) stray++;
            if (mem_done_out) lat = i;
        end
        read_req_in = 1'b0;
        check("pre_ld_latency", 32'(lat), 32'd6);
        check("pre_ld_data", mem_val_read_out, 32'hDEAD_BEEF);
        check("pre_no_if_done", 32'(stray), 32'd0);
        lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            @(negedge clk_in);
            if (if_done_out) lat = i;
        end
        if_req_in = 1'b0;
        check("pre_if_latency", 32'(lat), 32'd6);
        check("pre_if_data", inst_out, 32'h0000_0513);
        @(negedge clk_in);

        // Reset in the middle of a word store, after two bytes reached RAM.
        @(negedge clk_in);
        write_req_in = 1'b1; mem_addr_in = 32'h310; mem_width_in = MEM_WORD;
        mem_val_in = 32'hAABB_CCDD;
        repeat (3) @(negedge clk_in);
        done_snap = mem_done_cnt;
        rst_in = 1'b0; write_req_in = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_no_done", 32'(mem_done_cnt), 32'(done_snap));
        check("rst_ram", {ram['h313], ram['h312], ram['h311], ram['h310]}, 32'h0000_CCDD);
        run_txn("post_rst",  1, 32'h311, MEM_BYTE, 32'h0, 3, 32'h0000_00CC, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
